// File: rtl/bus_mailbox.sv
// ============================================================================
// Module   : bus_mailbox
// Purpose  : Memory-mapped FIFO mailbox on a hub device port (DATA/STATUS/
//            CTRL/THRESH). Optional threshold interrupt: BUS_MAILBOX_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] data_write,
  input  logic [3:0]  write_mask,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] data_read,
  output logic        ready,
  output logic        active,
  output logic        irq
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [1:0] c_reg_data   = 2'd0;
  localparam logic [1:0] c_reg_status = 2'd1;
  localparam logic [1:0] c_reg_ctrl   = 2'd2;
  localparam logic [1:0] c_reg_thresh = 2'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [31:0]          r_data_read;

  logic                 w_accept;
  logic                 w_is_write;
  logic                 w_is_read;
  logic [1:0]           w_reg;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_push_drop;
  logic                 w_pop;
  logic                 w_pop_miss;
  logic                 w_ctrl_wr;
  logic                 w_flush;
  logic                 w_clear;
  logic [31:0]          w_push_word;
  logic [31:0]          w_status;
  logic [31:0]          w_thresh_rd;
  logic [31:0]          w_read_value;
  logic                 w_unused;

  assign active   = (address[31:4] == BASE_ADDR[31:4]);
  assign w_reg    = address[3:2];
  assign w_unused = &{1'b0, address[1:0]};

  // The hub already gates wen/ren with active; re-check so a stray strobe is harmless.
  assign w_accept   = (r_state == S_IDLE) && active && (wen || ren);
  assign w_is_write = w_accept && wen;
  assign w_is_read  = w_accept && !wen;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_cnt_w'(DEPTH));

  assign w_push      = w_is_write && (w_reg == c_reg_data) && !w_full;
  assign w_push_drop = w_is_write && (w_reg == c_reg_data) && w_full;
  assign w_pop       = w_is_read  && (w_reg == c_reg_data) && !w_empty;
  assign w_pop_miss  = w_is_read  && (w_reg == c_reg_data) && w_empty;
  assign w_ctrl_wr   = w_is_write && (w_reg == c_reg_ctrl) && write_mask[0];
  assign w_flush     = w_ctrl_wr && data_write[0];
  assign w_clear     = w_ctrl_wr && data_write[1];

  assign w_push_word = {data_write[31:24] & {8{write_mask[3]}},
                        data_write[23:16] & {8{write_mask[2]}},
                        data_write[15:8]  & {8{write_mask[1]}},
                        data_write[7:0]   & {8{write_mask[0]}}};

  assign w_status = {16'h0000, 8'(r_count), 4'h0,
                     r_underflow, r_overflow, w_full, w_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        ready       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_read_value = 32'h0;
    if (w_is_read) begin
      case (w_reg)
        c_reg_data:   w_read_value = w_empty ? 32'h0 : r_mem[r_rd_ptr];
        c_reg_status: w_read_value = w_status;
        c_reg_thresh: w_read_value = w_thresh_rd;
        default:      w_read_value = 32'h0;
      endcase
    end
  end

  // data_read is only non-zero during RESP: it reloads with zero on every non-accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_data_read <= 32'h0;
    end else begin
      r_data_read <= w_read_value;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        r_count  <= r_count + c_cnt_w'(1);
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        r_count  <= r_count - c_cnt_w'(1);
      end
      if (w_clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_push_drop) r_overflow  <= 1'b1;
        if (w_pop_miss)  r_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  assign data_read = r_data_read;

`ifdef BUS_MAILBOX_IRQ_EN
  logic [7:0] r_threshold;
  logic       r_irq;

  // irq samples the already-updated count, so it trails count changes by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_threshold <= 8'd1;
      r_irq       <= 1'b0;
    end else begin
      if (w_is_write && (w_reg == c_reg_thresh) && write_mask[0]) begin
        r_threshold <= data_write[7:0];
      end
      r_irq <= (8'(r_count) >= r_threshold) && (r_threshold != 8'd0);
    end
  end

  assign w_thresh_rd = {24'h0, r_threshold};
  assign irq         = r_irq;
`else
  assign w_thresh_rd = 32'h0;
  assign irq         = 1'b0;
`endif

endmodule

`default_nettype wire
